// File: rtl/regfile_res_mc_pkg.sv
// ============================================================================
// Module  : regfile_res_mc_pkg
// Purpose : Shared defaults, snapshot state encoding and energy width helper
//           for the residual register file.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_res_mc_pkg;

  localparam int ROM_DATA_WIDTH = 16;
  localparam int RES_DW_DEFAULT = ROM_DATA_WIDTH;
  localparam int REG_RES_SIZE   = 16;

  typedef enum logic [0:0] {
    SNAP_IDLE  = 1'b0,
    SNAP_VALID = 1'b1
  } snap_state_t;

  // Sum of DEPTH squares of DW-bit signed words fits in 2*DW+AW bits.
  function automatic int energy_width(input int dw, input int aw);
    return 2 * dw + aw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_res_mc_energy.sv
// ============================================================================
// Module  : res_energy_acc
// Purpose : Running sum-of-squares accumulator, updated on each accepted write.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module res_energy_acc #(
  parameter int DW = 16,
  parameter int EW = 35
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          upd,
  input  logic [DW-1:0] old_val,
  input  logic [DW-1:0] new_val,
  output logic [EW-1:0] energy
);

  logic [2*DW-1:0] old_ext;
  logic [2*DW-1:0] new_ext;
  logic [2*DW-1:0] old_sq;
  logic [2*DW-1:0] new_sq;

  // Sign-extend to full product width; the low 2*DW bits hold the exact square.
  assign old_ext = {{DW{old_val[DW-1]}}, old_val};
  assign new_ext = {{DW{new_val[DW-1]}}, new_val};
  assign old_sq  = old_ext * old_ext;
  assign new_sq  = new_ext * new_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      energy <= '0;
    end else if (clr) begin
      energy <= '0;
    end else if (upd) begin
      energy <= energy - {{(EW-2*DW){1'b0}}, old_sq} + {{(EW-2*DW){1'b0}}, new_sq};
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_res_mc.sv
// ============================================================================
// Module  : regfile_res_mc
// Purpose : Residual register file with burst/addressed writes, registered
//           random read and frozen full-vector snapshot with valid/ack.
//           Optional energy tracking under macro REGFILE_RES_ENERGY_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_res_mc
  import regfile_res_mc_pkg::*;
#(
  parameter int DW    = RES_DW_DEFAULT,
  parameter int DEPTH = REG_RES_SIZE,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_en,
  input  logic                wr_auto,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  input  logic                snap_req,
  input  logic                snap_ack,
  output logic                snap_valid,
  output logic [DW*DEPTH-1:0] snap_data,
  output logic [AW:0]         wr_cnt,
  output logic                full,
  output logic                overflow
`ifdef REGFILE_RES_ENERGY_EN
  ,
  output logic [2*DW+AW-1:0]  res_energy,
  output logic [2*DW+AW-1:0]  snap_energy
`endif
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW-1:0] wr_idx;
  logic          wr_addr_ok;
  logic          rd_addr_ok;
  logic          acc_auto;
  logic          acc_addr;
  logic          capture;
  snap_state_t   state;
  snap_state_t   state_nxt;

  assign full       = (wr_cnt == DEPTH_W);
  assign wr_addr_ok = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_addr_ok = ({1'b0, rd_addr} < DEPTH_W);
  assign acc_auto   = wr_en & wr_auto & ~full & ~clr;
  assign acc_addr   = wr_en & ~wr_auto & wr_addr_ok & ~clr;
  assign wr_idx     = wr_auto ? ptr : wr_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr      <= '0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr      <= '0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (acc_auto || acc_addr) mem[wr_idx] <= wr_data;
      if (acc_auto) begin
        ptr    <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (wr_en && wr_auto && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= rd_addr_ok ? mem[rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SNAP_IDLE;
    else      state <= state_nxt;
  end

  // Requests are only honoured from IDLE; ack wins while a snapshot is held.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      SNAP_IDLE: begin
        if (snap_req) begin
          capture   = 1'b1;
          state_nxt = SNAP_VALID;
        end
      end
      SNAP_VALID: begin
        if (snap_ack) state_nxt = SNAP_IDLE;
      end
    endcase
  end

  assign snap_valid = (state == SNAP_VALID);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_data <= '0;
    end else if (capture) begin
      for (int i = 0; i < DEPTH; i++) snap_data[DW*i +: DW] <= mem[i];
    end
  end

`ifdef REGFILE_RES_ENERGY_EN
  logic [DW-1:0] old_val;

  assign old_val = (acc_auto || acc_addr) ? mem[wr_idx] : '0;

  res_energy_acc #(
    .DW (DW),
    .EW (energy_width(DW, AW))
  ) u_energy (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .upd     (acc_auto | acc_addr),
    .old_val (old_val),
    .new_val (wr_data),
    .energy  (res_energy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         snap_energy <= '0;
    else if (capture) snap_energy <= res_energy;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_res_mc.sv
// ============================================================================
// Module  : tb_regfile_res_mc
// Purpose : Directed self-checking bench for regfile_res_mc (DEPTH=8 and 6).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_res_mc;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0, wr_en = 1'b0, wr_auto = 1'b0;
  logic [2:0]   wr_addr = '0, rd_addr = '0;
  logic [15:0]  wr_data = '0;
  logic [15:0]  rd_data;
  logic         snap_req = 1'b0, snap_ack = 1'b0, snap_valid;
  logic [127:0] snap_data;
  logic [3:0]   wr_cnt;
  logic         full, overflow;

  logic         clr6 = 1'b0, wr_en6 = 1'b0, wr_auto6 = 1'b0;
  logic [2:0]   wr_addr6 = '0, rd_addr6 = '0;
  logic [15:0]  wr_data6 = '0;
  logic [15:0]  rd_data6;
  logic         snap_valid6;
  logic [95:0]  snap_data6;
  logic [3:0]   wr_cnt6;
  logic         full6, overflow6;

`ifdef REGFILE_RES_ENERGY_EN
  logic [34:0]  res_energy, snap_energy, res_energy6, snap_energy6;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_res_mc #(.DW(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_auto(wr_auto),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(snap_valid),
    .snap_data(snap_data), .wr_cnt(wr_cnt), .full(full), .overflow(overflow)
`ifdef REGFILE_RES_ENERGY_EN
    , .res_energy(res_energy), .snap_energy(snap_energy)
`endif
  );

  regfile_res_mc #(.DW(16), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .clr(clr6), .wr_en(wr_en6), .wr_auto(wr_auto6),
    .wr_addr(wr_addr6), .wr_data(wr_data6), .rd_addr(rd_addr6), .rd_data(rd_data6),
    .snap_req(1'b0), .snap_ack(1'b0), .snap_valid(snap_valid6),
    .snap_data(snap_data6), .wr_cnt(wr_cnt6), .full(full6), .overflow(overflow6)
`ifdef REGFILE_RES_ENERGY_EN
    , .res_energy(res_energy6), .snap_energy(snap_energy6)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_auto_t(input logic [15:0] d);
    wr_en = 1'b1; wr_auto = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0; wr_auto = 1'b0;
  endtask

  task automatic wr_addr_t(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_auto = 1'b0; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_snap_valid", 64'(snap_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    tick();
    rst = 1'b1;

    // Fill with 1..8
    for (int i = 1; i <= 8; i++) wr_auto_t(16'(i));
    chk("fill_wr_cnt", 64'(wr_cnt), 64'd8);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_overflow", 64'(overflow), 64'd0);
    rd_addr = 3'd3;
    tick();
    chk("rd_addr3", 64'(rd_data), 64'd4);
`ifdef REGFILE_RES_ENERGY_EN
    chk("energy_fill", 64'(res_energy), 64'd204);
`endif
    wr_auto_t(16'd99);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_wr_cnt", 64'(wr_cnt), 64'd8);
    rd_addr = 3'd0;
    tick();
    chk("ovf_mem0", 64'(rd_data), 64'd1);

    // Snapshot of the full vector, frozen against later writes
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("snap_valid1", 64'(snap_valid), 64'd1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("snap_e%0d", i), 64'(snap_data[16*i +: 16]), 64'(i + 1));
    wr_addr_t(3'd0, 16'hFFFB);
    chk("snap_frozen", 64'(snap_data[15:0]), 64'd1);
    chk("snap_held", 64'(snap_valid), 64'd1);
`ifdef REGFILE_RES_ENERGY_EN
    chk("energy_m5", 64'(res_energy), 64'd228);
    chk("snap_energy1", 64'(snap_energy), 64'd204);
`endif
    snap_req = 1'b1; snap_ack = 1'b1;
    tick();
    snap_req = 1'b0; snap_ack = 1'b0;
    chk("ack_release", 64'(snap_valid), 64'd0);
    chk("ack_no_capture", 64'(snap_data[15:0]), 64'd1);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("snap2_valid", 64'(snap_valid), 64'd1);
    chk("snap2_e0", 64'(snap_data[15:0]), 64'hFFFB);
`ifdef REGFILE_RES_ENERGY_EN
    chk("snap_energy2", 64'(snap_energy), 64'd228);
`endif
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
    chk("snap2_release", 64'(snap_valid), 64'd0);

    // clr beats a same-cycle write
    clr = 1'b1; wr_en = 1'b1; wr_auto = 1'b1; wr_data = 16'd77;
    tick();
    clr = 1'b0; wr_en = 1'b0; wr_auto = 1'b0;
    chk("clr_wr_cnt", 64'(wr_cnt), 64'd0);
    chk("clr_full", 64'(full), 64'd0);
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_keeps_snap", 64'(snap_data[15:0]), 64'hFFFB);
    rd_addr = 3'd0;
    tick();
    chk("clr_mem0", 64'(rd_data), 64'd0);
    rd_addr = 3'd7;
    tick();
    chk("clr_mem7", 64'(rd_data), 64'd0);

    // Capture sees pre-write contents; read sees pre-write on same cycle
    snap_req = 1'b1; wr_en = 1'b1; wr_auto = 1'b1; wr_data = 16'd42;
    tick();
    snap_req = 1'b0; wr_en = 1'b0; wr_auto = 1'b0;
    chk("cap_prewrite", 64'(snap_data[15:0]), 64'd0);
    chk("cap_wr_cnt", 64'(wr_cnt), 64'd1);
    rd_addr = 3'd0;
    tick();
    chk("rd_after_cap", 64'(rd_data), 64'd42);
    rd_addr = 3'd1;
    wr_addr_t(3'd1, 16'd11);
    chk("rd_prewrite", 64'(rd_data), 64'd0);
    tick();
    chk("rd_postwrite", 64'(rd_data), 64'd11);
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;

    // Energy build
    do_clr();
    wr_auto_t(16'hFFFD);
    wr_auto_t(16'd4);
    chk("en_wr_cnt", 64'(wr_cnt), 64'd2);
`ifdef REGFILE_RES_ENERGY_EN
    chk("energy_25", 64'(res_energy), 64'd25);
`endif
    wr_addr_t(3'd1, 16'd0);
    chk("en_wr_cnt_addr", 64'(wr_cnt), 64'd2);
`ifdef REGFILE_RES_ENERGY_EN
    chk("energy_9", 64'(res_energy), 64'd9);
`endif

    // Asynchronous reset mid-burst with a held snapshot
    do_clr();
    for (int i = 0; i < 5; i++) wr_auto_t(16'(10 + i));
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    rd_addr = 3'd0;
    tick();
    chk("pre_rst_cnt", 64'(wr_cnt), 64'd5);
    chk("pre_rst_valid", 64'(snap_valid), 64'd1);
    chk("pre_rst_rd", 64'(rd_data), 64'd10);
    #1 rst = 1'b0;
    #1;
    chk("arst_wr_cnt", 64'(wr_cnt), 64'd0);
    chk("arst_snap_valid", 64'(snap_valid), 64'd0);
    chk("arst_snap_data", 64'(snap_data[63:0]), 64'd0);
    chk("arst_rd_data", 64'(rd_data), 64'd0);
    tick();
    rst = 1'b1;
    wr_auto_t(16'd55);
    chk("post_rst_cnt", 64'(wr_cnt), 64'd1);
    rd_addr = 3'd0;
    tick();
    chk("post_rst_mem0", 64'(rd_data), 64'd55);

    // DEPTH=6: out-of-range addressing and wrap
    wr_en6 = 1'b1; wr_auto6 = 1'b0; wr_addr6 = 3'd7; wr_data6 = 16'd9;
    tick();
    wr_en6 = 1'b0;
    chk("d6_oor_cnt", 64'(wr_cnt6), 64'd0);
`ifdef REGFILE_RES_ENERGY_EN
    chk("d6_oor_energy", 64'(res_energy6), 64'd0);
`endif
    for (int i = 1; i <= 6; i++) begin
      wr_en6 = 1'b1; wr_auto6 = 1'b1; wr_data6 = 16'(i);
      tick();
    end
    wr_en6 = 1'b0; wr_auto6 = 1'b0;
    chk("d6_full", 64'(full6), 64'd1);
    chk("d6_wr_cnt", 64'(wr_cnt6), 64'd6);
`ifdef REGFILE_RES_ENERGY_EN
    chk("d6_energy", 64'(res_energy6), 64'd91);
`endif
    rd_addr6 = 3'd5;
    tick();
    chk("d6_rd5", 64'(rd_data6), 64'd6);
    rd_addr6 = 3'd6;
    tick();
    chk("d6_rd6_oor", 64'(rd_data6), 64'd0);
    wr_en6 = 1'b1; wr_auto6 = 1'b1; wr_data6 = 16'd99;
    tick();
    wr_en6 = 1'b0; wr_auto6 = 1'b0;
    chk("d6_overflow", 64'(overflow6), 64'd1);
    rd_addr6 = 3'd0;
    tick();
    chk("d6_wrap_mem0", 64'(rd_data6), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_res_mc.md
Name: regfile_res_mc

Overview:
- Parametrised residual register file for the OMP residual-update stage; successor to the fixed-size residual store.
- Holds DEPTH signed residual words of DW bits.
- Write side: auto-incrementing burst writes or addressed overwrites.
- Read side: one registered random-access port plus a full-vector snapshot with a valid/ack handshake, so the correlation stage sees a frozen copy while the next residual is written.

Parameters:
- DW, 16, residual word width (signed two's complement)
- DEPTH, 16, number of entries (need not be a power of two, >=2)
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear: entries, pointer, count, overflow, energy
- wr_en  in  1  write strobe
- wr_auto  in  1  1: write at internal pointer; 0: write at wr_addr
- wr_addr  in  AW  explicit write address (used when wr_auto=0)
- wr_data  in  DW  write data
- rd_addr  in  AW  random read address
- rd_data  out  DW  registered read data
- snap_req  in  1  request full-vector snapshot
- snap_ack  in  1  consumer releases snapshot
- snap_valid  out  1  snapshot held and stable
- snap_data  out  DW*DEPTH  entry i at bits [DW*(i+1)-1 -: DW]
- wr_cnt  out  AW+1  auto writes since clear, saturating at DEPTH
- full  out  1  wr_cnt == DEPTH
- overflow  out  1  sticky: auto write attempted while full

Behaviour:
- Reset (rst=0, async): all entries, rd_data, snap_data, wr_cnt, pointer, energy = 0; snap_valid, full, overflow = 0; snapshot FSM in IDLE.
- Priority per cycle: clr > write. clr zeroes entries, pointer, wr_cnt, overflow and energy. It does not touch snap_data, snap_valid or the FSM.
- Auto write (wr_en & wr_auto & !full): mem[ptr] <= wr_data. ptr wraps to 0 after DEPTH-1. wr_cnt increments.
- Auto write while full: data dropped, ptr and wr_cnt unchanged, overflow <= 1.
- Addressed write (wr_en & !wr_auto): mem[wr_addr] <= wr_data if wr_addr < DEPTH, otherwise ignored. ptr and wr_cnt unchanged.
- Read: rd_data <= mem[rd_addr] every cycle, 1-cycle latency. Value is the pre-write contents on a same-cycle write to that address. rd_addr >= DEPTH gives 0.
- Snapshot FSM, two states:
  - IDLE: snap_req=1 → snap_data <= all entries (pre-write contents on the capture edge); go to VALID; snap_valid=1 from the next cycle.
  - VALID: snap_data frozen regardless of writes or clr. snap_ack=1 → IDLE; snap_valid=0 next cycle. snap_req ignored in VALID.
  - snap_req and snap_ack high together in VALID: release only; a new capture needs snap_req in IDLE.
- Reset mid-burst or mid-snapshot: everything returns to reset values immediately; no partial state survives.

Optional Feature:
- Macro: REGFILE_RES_ENERGY_EN
- Defined:
  - Adds output res_energy, width 2*DW+AW, unsigned: running sum of squares of all entries, updated in the same cycle as each accepted write.
  - Update rule: energy <= energy - old^2 + new^2, where old is the entry being overwritten (0 after clr).
  - Also adds snap_energy, captured together with snap_data; this is the OMP stopping-criterion input.
  - Squares are computed on signed DW operands.
- Not defined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package / define header:
  - ROM_DATA_WIDTH-derived default for DW
  - REG_RES_SIZE default for DEPTH
  - snapshot state encoding (SNAP_IDLE=0, SNAP_VALID=1)
  - energy width macro
- One sub-module is natural: res_energy_acc, holding the square/subtract/add datapath and accumulator register, instantiated only under REGFILE_RES_ENERGY_EN.

Test Plan (DW=16, DEPTH=8):
- Reset release, 8 auto writes 1..8 → wr_cnt=8, full=1. rd_addr=3 gives 4 one cycle later. Ninth write (99) → overflow=1, mem unchanged.
- After fill, snap_req for 1 cycle → snap_valid=1 next cycle, snap_data = {8,7,...,1}. Addressed write mem[0]=-5 while VALID → snap_data unchanged. snap_ack → snap_valid=0. New snap_req → entry 0 reads 0xFFFB.
- Same-cycle snap_req and auto write of 42 to ptr 0 after clr → captured entry 0 = 0; rd_addr=0 on the following cycle gives 42.
- clr with wr_en=1 in the same cycle → all entries 0, wr_cnt=0, overflow=0, write discarded.
- Energy build: write -3, 4 → res_energy=25. Addressed overwrite of entry 1 with 0 → 9. Out-of-range wr_addr with DEPTH=6 → no change.
- Assert rst low mid-burst (wr_cnt=5) with snap_valid=1 → all outputs 0 asynchronously. After release, the first auto write lands at address 0.
